// File: rtl/spi_pkg.sv
// Shared definitions for the SPI master controller: op encodings, frame sizes,
// FSM state type and the frame-word builder used at command accept.
package spi_pkg;

  localparam logic [1:0] OP_WR_ADDR = 2'b00;
  localparam logic [1:0] OP_WR_DATA = 2'b01;
  localparam logic [1:0] OP_RD_ADDR = 2'b10;
  localparam logic [1:0] OP_RD_DATA = 2'b11;

  localparam int FRAME_BITS = 11;
  localparam int DATA_BITS  = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_SHIFT,
    ST_TURN,
    ST_RECV,
    ST_GAP
  } state_t;

  typedef struct packed {
    logic [1:0]           op;
    logic [DATA_BITS-1:0] data;
  } cmd_t;

  // The slave expects op[1] twice: once to pick read/write, once inside the op field.
  function automatic logic [FRAME_BITS-1:0] build_frame(input cmd_t c);
    return {c.op[1], c.op[1], c.op[0], c.data};
  endfunction

endpackage

// File: rtl/spi_master_ctrl.sv
// SPI master feeding SPI_wrapper: serialises one RAM command per handshake and,
// for rd_data, collects the 8-bit MISO reply after RD_LAT turnaround cycles.
module spi_master_ctrl
  import spi_pkg::*;
#(
  parameter int RD_LAT = 1,
  parameter int GAP    = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [1:0]           cmd_op,
  input  logic [DATA_BITS-1:0] cmd_data,
  output logic                 rsp_valid,
  output logic [DATA_BITS-1:0] rsp_data,
  output logic                 busy,
  output logic                 SS_n,
  output logic                 MOSI,
  input  logic                 MISO
);

  localparam logic [3:0] SHIFT_LD = 4'(FRAME_BITS - 1);
  localparam logic [3:0] RECV_LD  = 4'(DATA_BITS - 1);
  localparam logic [3:0] TURN_LD  = (RD_LAT > 0) ? 4'(RD_LAT - 1) : 4'd0;
  localparam logic [3:0] GAP_LD   = 4'(GAP - 1);

  state_t                 state, state_nxt;
  logic [3:0]             cnt;
  logic [FRAME_BITS-1:0]  tx_sh;
  logic [1:0]             op_q;
  logic [DATA_BITS-1:0]   rx_sh;
  logic                   cnt_zero;
  cmd_t                   cmd_in;

  assign cnt_zero  = (cnt == 4'd0);
  assign cmd_ready = (state == ST_IDLE);
  assign busy      = (state != ST_IDLE);
  assign cmd_in    = '{op: cmd_op, data: cmd_data};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:  if (cmd_valid) state_nxt = ST_START;
      ST_START: state_nxt = ST_SHIFT;
      ST_SHIFT: if (cnt_zero) begin
                  if (op_q != OP_RD_DATA) state_nxt = ST_GAP;
                  else if (RD_LAT > 0)    state_nxt = ST_TURN;
                  else                    state_nxt = ST_RECV;
                end
      ST_TURN:  if (cnt_zero) state_nxt = ST_RECV;
      ST_RECV:  if (cnt_zero) state_nxt = ST_GAP;
      ST_GAP:   if (cnt_zero) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // cnt is reloaded on every state entry, so nothing carries over between frames.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      SS_n      <= 1'b1;
      MOSI      <= 1'b0;
      cnt       <= 4'd0;
      tx_sh     <= '0;
      op_q      <= OP_WR_ADDR;
      rx_sh     <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
    end else begin
      rsp_valid <= 1'b0;
      unique case (state)
        ST_IDLE: if (cmd_valid) begin
          tx_sh <= build_frame(cmd_in);
          op_q  <= cmd_op;
          rx_sh <= '0;
          cnt   <= 4'd0;
          SS_n  <= 1'b0;
          MOSI  <= 1'b0;
        end
        ST_START: begin
          MOSI  <= tx_sh[FRAME_BITS-1];
          tx_sh <= {tx_sh[FRAME_BITS-2:0], 1'b0};
          cnt   <= SHIFT_LD;
        end
        ST_SHIFT: begin
          if (!cnt_zero) begin
            MOSI  <= tx_sh[FRAME_BITS-1];
            tx_sh <= {tx_sh[FRAME_BITS-2:0], 1'b0};
            cnt   <= cnt - 4'd1;
          end else begin
            MOSI <= 1'b0;
            if (op_q != OP_RD_DATA) begin
              SS_n <= 1'b1;
              cnt  <= GAP_LD;
            end else if (RD_LAT > 0) begin
              cnt  <= TURN_LD;
            end else begin
              cnt  <= RECV_LD;
            end
          end
        end
        ST_TURN: cnt <= cnt_zero ? RECV_LD : cnt - 4'd1;
        ST_RECV: begin
          rx_sh <= {rx_sh[DATA_BITS-2:0], MISO};
          if (cnt_zero) begin
            rsp_data  <= {rx_sh[DATA_BITS-2:0], MISO};
            rsp_valid <= 1'b1;
            SS_n      <= 1'b1;
            cnt       <= GAP_LD;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        ST_GAP: if (!cnt_zero) cnt <= cnt - 4'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Directed bench: three controllers (RD_LAT 1, 0, 3) each talking to a
// behavioural SPI_wrapper model; lane 0 carries the main sequence.
module tb_spi_master_ctrl;
  localparam int NUM_LANES = 3;
  localparam int GAP = 2;
  localparam int LAT [NUM_LANES] = '{1, 0, 3};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [NUM_LANES-1:0]       cmd_valid = '0;
  logic [NUM_LANES-1:0]       cmd_ready, rsp_valid, busy, ss_n, mosi;
  logic [NUM_LANES-1:0][1:0]  cmd_op = '0;
  logic [NUM_LANES-1:0][7:0]  cmd_data = '0;
  logic [NUM_LANES-1:0][7:0]  rsp_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    localparam int L = LAT[g];
    logic        miso = 1'b0;
    logic [11:0] sh = '0, frame = '0;
    logic [7:0]  wr_a = '0, rd_a = '0, rep = '0, last_rsp = '0;
    logic        rd_pend = 1'b0;
    logic [7:0]  mem [256];
    int sc = 0, c = 0, len = 0, frames = 0, rsp_cnt = 0;
    int gap_run = 0, gap_ok = 0, gap_bad = 0;

    initial for (int i = 0; i < 256; i++) mem[i] = 8'h00;

    spi_master_ctrl #(.RD_LAT(L), .GAP(GAP)) u_dut (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid(cmd_valid[g]), .cmd_ready(cmd_ready[g]),
      .cmd_op(cmd_op[g]), .cmd_data(cmd_data[g]),
      .rsp_valid(rsp_valid[g]), .rsp_data(rsp_data[g]),
      .busy(busy[g]), .SS_n(ss_n[g]), .MOSI(mosi[g]), .MISO(miso)
    );

    // Slave model: the first low-SS sample is the slave's command-check slot.
    always @(negedge clk) begin
      if (!ss_n[g]) begin
        c = sc + 1;
        sc = c;
        if (c <= 12) sh = {sh[10:0], mosi[g]};
        if (c == 12) begin
          frame = sh;
          case ({sh[9], sh[8]})
            2'b00: wr_a = sh[7:0];
            2'b01: mem[wr_a] = sh[7:0];
            2'b10: rd_a = sh[7:0];
            default: begin rep = mem[rd_a]; rd_pend = 1'b1; end
          endcase
        end
        if (rd_pend && c >= 13 + L && c <= 20 + L) miso = rep[3'(20 + L - c)];
      end else if (sc != 0) begin
        len = sc; frames++; sc = 0; miso = 1'b0; rd_pend = 1'b0;
      end
      if (rsp_valid[g]) begin rsp_cnt++; last_rsp = rsp_data[g]; end
      if (ss_n[g] && busy[g]) gap_run++;
      else if (gap_run != 0) begin
        if (gap_run == GAP) gap_ok++; else gap_bad++;
        gap_run = 0;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ready(input int idx);
    int n = 0;
    while (!cmd_ready[idx] && n < 400) begin @(negedge clk); n++; end
    chk("ready_timeout", 32'(n < 400), 32'd1);
  endtask

  task automatic send(input int idx, input logic [1:0] op, input logic [7:0] d);
    @(negedge clk);
    wait_ready(idx);
    cmd_valid[idx] = 1'b1; cmd_op[idx] = op; cmd_data[idx] = d;
    @(negedge clk);
    cmd_valid[idx] = 1'b0; cmd_op[idx] = ~op; cmd_data[idx] = ~d;
    @(negedge clk);
    wait_ready(idx);
    @(negedge clk);
  endtask

  int rc0, f0, gok0, gbad0, acc, t, last_t, guard;
  logic rdy;
  logic [7:0] a, d, r;
  logic [7:0] exp_mem [256];
  logic [7:0] wa [10];

  initial begin
    // power-on reset values
    #12;
    chk("rst_ss_n", 32'(ss_n[0]), 32'd1);
    chk("rst_mosi", 32'(mosi[0]), 32'd0);
    chk("rst_ready", 32'(cmd_ready[0]), 32'd1);
    chk("rst_busy", 32'(busy[0]), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid[0]), 32'd0);
    chk("rst_rsp_data", 32'(rsp_data[0]), 32'h00);
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // write path
    rc0 = g_lane[0].rsp_cnt;
    send(0, 2'b00, 8'h3C);
    chk("wr_addr_frame", 32'(g_lane[0].frame), 32'h03C);
    chk("wr_addr_len", 32'(g_lane[0].len), 32'd12);
    send(0, 2'b01, 8'hA5);
    chk("wr_data_frame", 32'(g_lane[0].frame), 32'h1A5);
    chk("wr_mem_3c", 32'(g_lane[0].mem[8'h3C]), 32'hA5);
    chk("wr_no_rsp", 32'(g_lane[0].rsp_cnt - rc0), 32'd0);

    // read path
    send(0, 2'b10, 8'h3C);
    chk("rd_addr_frame", 32'(g_lane[0].frame), 32'h63C);
    chk("rd_addr_no_rsp", 32'(g_lane[0].rsp_cnt - rc0), 32'd0);
    send(0, 2'b11, 8'h00);
    chk("rd_data_frame", 32'(g_lane[0].frame), 32'h700);
    chk("rd_rsp_cnt", 32'(g_lane[0].rsp_cnt - rc0), 32'd1);
    chk("rd_rsp_data", 32'(g_lane[0].last_rsp), 32'hA5);
    chk("rd_ss_low_len", 32'(g_lane[0].len), 32'd21);
    send(0, 2'b00, 8'h11);
    chk("rsp_data_hold", 32'(rsp_data[0]), 32'hA5);
    chk("hold_no_rsp", 32'(g_lane[0].rsp_cnt - rc0), 32'd1);

    // reset mid-SHIFT of a wr_addr frame
    @(negedge clk);
    cmd_valid[0] = 1'b1; cmd_op[0] = 2'b00; cmd_data[0] = 8'h3C;
    @(negedge clk); cmd_valid[0] = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_ss_n", 32'(ss_n[0]), 32'd1);
    chk("midrst_mosi", 32'(mosi[0]), 32'd0);
    chk("midrst_rsp_valid", 32'(rsp_valid[0]), 32'd0);
    chk("midrst_rsp_data", 32'(rsp_data[0]), 32'h00);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_ready", 32'(cmd_ready[0]), 32'd1);
    rc0 = g_lane[0].rsp_cnt;
    send(0, 2'b00, 8'h10);
    send(0, 2'b01, 8'h77);
    chk("post_rst_frame", 32'(g_lane[0].frame), 32'h177);
    send(0, 2'b10, 8'h10);
    send(0, 2'b11, 8'h00);
    chk("post_rst_rsp", 32'(g_lane[0].last_rsp), 32'h77);
    chk("post_rst_rsp_cnt", 32'(g_lane[0].rsp_cnt - rc0), 32'd1);

    // handshake: cmd_valid held high across 10 alternating commands
    f0 = g_lane[0].frames; gok0 = g_lane[0].gap_ok; gbad0 = g_lane[0].gap_bad;
    @(negedge clk);
    acc = 0; t = 0; last_t = 0; guard = 0;
    cmd_valid[0] = 1'b1; cmd_op[0] = 2'b00; cmd_data[0] = 8'h40;
    while (acc < 10 && guard < 1000) begin
      rdy = cmd_ready[0];
      @(negedge clk); guard++; t++;
      if (rdy) begin
        if (acc > 0) chk("hs_spacing", 32'(t - last_t), 32'(13 + GAP));
        last_t = t; acc++;
        if (acc[0]) begin cmd_op[0] = 2'b01; cmd_data[0] = 8'(8'h90 + acc); end
        else begin cmd_op[0] = 2'b00; cmd_data[0] = 8'(8'h40 + acc / 2); end
      end
    end
    cmd_valid[0] = 1'b0;
    chk("hs_accepts", 32'(acc), 32'd10);
    @(negedge clk); wait_ready(0); repeat (2) @(negedge clk);
    chk("hs_frames", 32'(g_lane[0].frames - f0), 32'd10);
    chk("hs_gap_ok", 32'(g_lane[0].gap_ok - gok0), 32'd10);
    chk("hs_gap_bad", 32'(g_lane[0].gap_bad - gbad0), 32'd0);
    for (int j = 0; j < 5; j++)
      chk("hs_mem", 32'(g_lane[0].mem[8'(8'h40 + j)]), 32'(8'h91 + 2 * j));

    // RD_LAT sweep on lanes 1 (RD_LAT=0) and 2 (RD_LAT=3)
    for (int i = 1; i < NUM_LANES; i++) begin
      send(i, 2'b00, 8'h55);
      send(i, 2'b01, 8'h5A);
      send(i, 2'b10, 8'h55);
      send(i, 2'b11, 8'h00);
    end
    chk("lat0_rsp", 32'(g_lane[1].last_rsp), 32'h5A);
    chk("lat0_len", 32'(g_lane[1].len), 32'd20);
    chk("lat0_cnt", 32'(g_lane[1].rsp_cnt), 32'd1);
    chk("lat3_rsp", 32'(g_lane[2].last_rsp), 32'h5A);
    chk("lat3_len", 32'(g_lane[2].len), 32'd23);
    chk("lat3_cnt", 32'(g_lane[2].rsp_cnt), 32'd1);

    // random write/read-back loop on lane 0
    rc0 = g_lane[0].rsp_cnt;
    for (int i = 0; i < 10; i++) begin
      a = 8'($urandom_range(0, 255));
      d = 8'($urandom_range(0, 255));
      send(0, 2'b00, a);
      send(0, 2'b01, d);
      exp_mem[a] = d; wa[i] = a;
      r = wa[$urandom_range(0, i)];
      send(0, 2'b10, r);
      send(0, 2'b11, 8'h00);
      chk("rand_rd", 32'(g_lane[0].last_rsp), 32'(exp_mem[r]));
    end
    chk("rand_rsp_cnt", 32'(g_lane[0].rsp_cnt - rc0), 32'd10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/spi_master_ctrl.md
Name: spi_master_ctrl

Overview:
- SPI master controller that sits directly upstream of SPI_wrapper (SPI slave plus single-port RAM).
- Accepts one RAM command per valid/ready handshake: write address, write data, read address or read data.
- Serialises each command into an SS_n/MOSI frame and, for read-data commands, deserialises the 8-bit MISO reply.
- Returns the reply on a one-cycle response strobe; lets system logic access the RAM without bit-banging.

Parameters:
- RD_LAT, 1, turnaround cycles between the last MOSI bit and the first MISO sample (range 0..7).
- GAP, 2, cycles SS_n is held high after every frame before the next command is accepted (range 1..15).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  controller can accept a command; high only in IDLE.
- cmd_op  in  2  00 wr_addr, 01 wr_data, 10 rd_addr, 11 rd_data.
- cmd_data  in  8  address or data payload; don't-care for rd_data.
- rsp_valid  out  1  one-cycle pulse; rsp_data valid.
- rsp_data  out  8  byte received on MISO, MSB first.
- busy  out  1  high in every state except IDLE.
- SS_n  out  1  slave select, active low, registered.
- MOSI  out  1  serial data to slave, registered.
- MISO  in  1  serial data from slave.

Behaviour:
- Reset (async, rst_n low):
  - Outputs: SS_n=1, MOSI=0, cmd_ready=1, busy=0, rsp_valid=0, rsp_data=0x00.
  - State forced to IDLE. A frame in progress is abandoned; no response is issued.
- Frame word, latched at accept: {op[1], op[1], op[0], data[7:0]}, 11 bits, sent MSB first.
- States: IDLE, START, SHIFT, TURN, RECV, GAP.
- IDLE:
  - On cmd_valid&&cmd_ready at edge k: latch cmd_op/cmd_data, SS_n<=0, MOSI<=0, go to START.
  - cmd_valid while not ready is ignored. Input changes after accept have no effect.
- START: one cycle (slave IDLE->CHK_CMD). At edge k+1, MOSI<=frame[10], go to SHIFT.
- SHIFT:
  - Edges k+1..k+11 drive frame[10]..frame[0], one bit per cycle. A 4-bit counter tracks position.
  - At edge k+12:
    - op!=11: SS_n<=1, MOSI<=0, go to GAP.
    - op==11: go to TURN if RD_LAT>0, else go to RECV.
- TURN: hold SS_n=0, MOSI=0 for RD_LAT cycles.
- RECV:
  - 8 consecutive rising edges, each doing rx<={rx[6:0],MISO}.
  - On the 8th edge: rsp_data<=shifted value, rsp_valid<=1 for exactly one cycle, SS_n<=1, go to GAP.
- GAP:
  - SS_n=1 for GAP cycles, then go to IDLE and raise cmd_ready.
  - Minimum accept-to-accept spacing: 13+GAP cycles for writes/rd_addr; 13+RD_LAT+8+GAP for rd_data.
- rsp_data holds its value until the next rd_data response.
- rsp_valid never asserts for op 00/01/10.
- MISO is sampled only in RECV.
- Counters saturate/clear on state entry; no wrap-around across frames.

Decomposition:
- Shared package spi_pkg:
  - Op encodings OP_WR_ADDR=2'b00, OP_WR_DATA=2'b01, OP_RD_ADDR=2'b10, OP_RD_DATA=2'b11.
  - FRAME_BITS=11, DATA_BITS=8.
  - State enum.
- No sub-module: FSM, bit counter, TX and RX shift registers are inline. The block is roughly 150-200 lines.

Test Plan:
- Reset: assert rst_n=0 mid-SHIFT of a wr_addr frame.
  - Outputs go to reset values immediately (SS_n=1, MOSI=0, rsp_valid=0).
  - After release, cmd_ready=1 and the next command completes normally.
- Write path: wr_addr 0x3C then wr_data 0xA5 into SPI_wrapper.
  - MOSI sequence 0,0,0,00111100 then 0,0,1,10100101.
  - dut RAM memory[0x3C]==0xA5 and rsp_valid never pulses.
- Read path: rd_addr 0x3C then rd_data with memory[0x3C]=0xA5.
  - Exactly one rsp_valid pulse, rsp_data=0xA5.
  - SS_n low for 12+RD_LAT+8 cycles on the rd_data frame.
- Handshake:
  - Hold cmd_valid=1 continuously with alternating commands; each is accepted only when cmd_ready=1.
  - SS_n high for exactly GAP=2 cycles between frames.
  - No command is lost or duplicated (count 10 frames).
- Timing sweep: RD_LAT=0 and RD_LAT=3 against a behavioural slave driving MISO byte 0x5A at the matching offset -> rsp_data=0x5A in both builds.
- Loop: 10 random wr_addr/wr_data/rd_addr/rd_data sequences -> every rsp_data equals the byte written to that address.
